// File: rtl/cache_cmd_scheduler_pkg.sv
// Shared cache command encoding plus scheduler state and constants.
package cachepkg;

  typedef enum logic [3:0] {
    CMD_NOP        = 4'h0,
    CMD_READ       = 4'h1,
    CMD_WRITE      = 4'h2,
    CMD_INVALIDATE = 4'h3,
    CMD_FLUSH      = 4'h4,
    CMD_RESET      = 4'hF
  } cmd_t;

  typedef enum logic [1:0] {
    S_RST,
    S_WAIT,
    S_RUN
  } sched_state_t;

  localparam int unsigned STARVE_LIMIT = 4;

endpackage

// File: rtl/cache_cmd_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_cmd_scheduler.sv
// Cache command port sequencer/arbiter: power-on RESET, settle wait, snoop-priority round-robin.
// Optional statistics outputs are enabled by defining CACHE_SCHED_STATS_EN.
module cache_cmd_scheduler
  import cachepkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*4-1:0]        req_op,
  input  logic [NREQ*ADDRBITS-1:0] req_addr,
  output logic [NREQ-1:0]          gnt,
  input  logic                     cache_busy,
  output logic [3:0]               cache_op,
  output logic [ADDRBITS-1:0]      cache_addr,
  output logic                     ready
`ifdef CACHE_SCHED_STATS_EN
  ,
  output logic [NREQ*32-1:0]       grant_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int unsigned PW  = $clog2(NREQ);
  localparam int unsigned RPW = (NREQ - 1 > 1) ? $clog2(NREQ - 1) : 1;
  localparam logic [7:0]  WAIT_LAST  = 8'(INIT_CYCLES - 1);
  localparam logic [2:0]  STARVE_MAX = 3'(STARVE_LIMIT);

  sched_state_t          state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [2:0]            starve_q, starve_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]            op_q, op_d;
  logic [ADDRBITS-1:0]   addr_q, addr_d;
  logic                  ready_q, ready_d;

  logic [NREQ-2:0]       rr_win;
  logic                  rr_valid;
  logic                  xfer;
  logic [3:0]            sel_op;
  logic [ADDRBITS-1:0]   sel_addr;

  rr_picker #(.N(NREQ - 1), .PW(RPW)) u_rr (
    .req_i   (req[NREQ-1:1]),
    .ptr_i   (RPW'(rr_ptr_q - 1'b1)),
    .win_o   (rr_win),
    .valid_o (rr_valid)
  );

  always_comb begin
    gnt = '0;
    if (!reset && state_q == S_RUN && !cache_busy) begin
      if (req[0] && !(starve_q >= STARVE_MAX && rr_valid)) gnt[0] = 1'b1;
      else                                                  gnt[NREQ-1:1] = rr_win;
    end
    xfer     = |gnt;
    sel_op   = CMD_NOP;
    sel_addr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op   = req_op[i*4 +: 4];
        sel_addr = req_addr[i*ADDRBITS +: ADDRBITS];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int unsigned j = 0; j < NREQ - 1; j++) begin
      if (gnt[j+1]) rr_ptr_d = (j == NREQ - 2) ? PW'(1) : PW'(j + 2);
    end
    starve_d = starve_q;
    if (!req[0] || (|gnt[NREQ-1:1])) starve_d = '0;
    else if (gnt[0]) begin
      if (!(|req[NREQ-1:1]))       starve_d = '0;
      else if (starve_q < STARVE_MAX) starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    op_d    = CMD_NOP;
    addr_d  = '0;
    case (state_q)
      // After a hard reset the output register still holds NOP, so S_RST
      // lingers one cycle to put RESET on the port before moving on.
      S_RST: begin
        if (op_q == CMD_RESET) state_d = S_WAIT;
        else                   op_d    = CMD_RESET;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_RUN;
        else                     wait_d  = wait_q + 8'd1;
      end
      S_RUN: begin
        if (xfer) begin
          if (sel_op == CMD_RESET) begin
            state_d = S_RST;
            op_d    = CMD_RESET;
          end else begin
            op_d   = sel_op;
            addr_d = sel_addr;
          end
        end
      end
      default: state_d = S_RST;
    endcase
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RST;
      wait_q   <= '0;
      starve_q <= '0;
      rr_ptr_q <= PW'(1);
      op_q     <= CMD_NOP;
      addr_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
    end
  end

  assign cache_op   = op_q;
  assign cache_addr = addr_q;
  assign ready      = ready_q;

`ifdef CACHE_SCHED_STATS_EN
  logic [NREQ*32-1:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]        stall_q, stall_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i] && grant_cnt_q[i*32 +: 32] != '1)
        grant_cnt_d[i*32 +: 32] = grant_cnt_q[i*32 +: 32] + 32'd1;
    end
    stall_d = stall_q;
    if (state_q == S_RUN && (|req) && !xfer) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt_q <= '0;
      stall_q     <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign grant_count = grant_cnt_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_cache_cmd_scheduler.sv
// Scoreboard bench for cache_cmd_scheduler; checks statistics when CACHE_SCHED_STATS_EN is defined.
module tb_cache_cmd_scheduler;
  import cachepkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned INIT = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic              cache_busy;
  logic [3:0]        cache_op;
  logic [AW-1:0]     cache_addr;
  logic              ready;
`ifdef CACHE_SCHED_STATS_EN
  logic [NREQ*32-1:0] grant_count;
  logic [31:0]        stall_count;
  int unsigned        gtally[NREQ];
  int unsigned        stally;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    bit          chk_addr;
  } sb_t;

  sb_t         sb_q[$];
  logic [3:0]  op_m[NREQ];
  logic [31:0] addr_m[NREQ];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cache_cmd_scheduler #(
    .NREQ(NREQ), .ADDRBITS(AW), .INIT_CYCLES(INIT)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .gnt(gnt), .cache_busy(cache_busy), .cache_op(cache_op), .cache_addr(cache_addr),
    .ready(ready)
`ifdef CACHE_SCHED_STATS_EN
    , .grant_count(grant_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic [3:0] op, input logic [31:0] a);
    req_op[i*4 +: 4]    = op;
    req_addr[i*AW +: AW] = a;
    op_m[i]   = op;
    addr_m[i] = a;
    req[i]    = 1'b1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input bit chk);
    sb_t e;
    e.op = op; e.addr = a; e.chk_addr = chk;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    check_eq({tag, ".sb_empty"}, 64'(sb_q.size() == 0), 64'd0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, ".op"}, 64'(cache_op), 64'(e.op));
      if (e.chk_addr) check_eq({tag, ".addr"}, 64'(cache_addr), 64'(e.addr));
    end
  endtask

  // One clock: check gnt/ready and this cycle's cache output, then queue the next cycle's output.
  task automatic tick(input string tag, input logic [NREQ-1:0] exp_gnt, input logic exp_ready,
                      input bit rst_next);
    @(negedge clock);
    check_eq({tag, ".gnt"}, 64'(gnt), 64'(exp_gnt));
    check_eq({tag, ".ready"}, 64'(ready), 64'(exp_ready));
    pop_check(tag);
`ifdef CACHE_SCHED_STATS_EN
    for (int unsigned i = 0; i < NREQ; i++) if (exp_gnt[i]) gtally[i]++;
    if (exp_ready && (|req) && exp_gnt == '0) stally++;
`endif
    if (rst_next) push(CMD_RESET, 32'h0, 1'b0);
    else if (exp_gnt != '0) begin
      for (int unsigned i = 0; i < NREQ; i++)
        if (exp_gnt[i]) push(op_m[i], addr_m[i], op_m[i] != CMD_RESET);
    end else push(CMD_NOP, 32'h0, 1'b1);
    @(posedge clock);
    #1;
  endtask

`ifdef CACHE_SCHED_STATS_EN
  task automatic check_stats(input string tag);
    for (int unsigned i = 0; i < NREQ; i++)
      check_eq($sformatf("%s.grant%0d", tag, i), 64'(grant_count[i*32 +: 32]), 64'(gtally[i]));
    check_eq({tag, ".stall"}, 64'(stall_count), 64'(stally));
  endtask
`endif

  initial begin
    reset      = 1'b1;
    cache_busy = 1'b0;
    req        = '0;
    req_op     = '0;
    req_addr   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_m[i] = CMD_NOP; addr_m[i] = '0;
    end
`ifdef CACHE_SCHED_STATS_EN
    for (int unsigned i = 0; i < NREQ; i++) gtally[i] = 0;
    stally = 0;
`endif

    @(posedge clock);
    @(negedge clock);
    check_eq("rst.op", 64'(cache_op), 64'(CMD_NOP));
    check_eq("rst.addr", 64'(cache_addr), 64'd0);
    check_eq("rst.ready", 64'(ready), 64'd0);
    check_eq("rst.gnt", 64'(gnt), 64'd0);
`ifdef CACHE_SCHED_STATS_EN
    check_stats("rst");
`endif
    @(posedge clock);
    @(posedge clock);
    #1;
    // Snoop request pending before the settle completes: must wait for ready.
    set_req(0, CMD_READ, 32'h40);
    reset = 1'b0;
    push(CMD_NOP, 32'h0, 1'b1);
    tick("por0", 4'b0000, 1'b0, 1'b1);
    tick("por1", 4'b0000, 1'b0, 1'b0);
    tick("por2", 4'b0000, 1'b0, 1'b0);
    tick("por3", 4'b0000, 1'b0, 1'b0);
    tick("por4", 4'b0001, 1'b1, 1'b0);
    req[0] = 1'b0;

    set_req(1, CMD_READ,  32'h100);
    set_req(2, CMD_WRITE, 32'h200);
    set_req(3, CMD_READ,  32'h300);
    tick("rr1", 4'b0010, 1'b1, 1'b0); req[1] = 1'b0;
    tick("rr2", 4'b0100, 1'b1, 1'b0); req[2] = 1'b0;
    tick("rr3", 4'b1000, 1'b1, 1'b0); req[3] = 1'b0;
    tick("rr_idle", 4'b0000, 1'b1, 1'b0);

    set_req(0, CMD_INVALIDATE, 32'hABC0);
    set_req(2, CMD_READ, 32'h2A0);
    tick("snp0", 4'b0001, 1'b1, 1'b0); req[0] = 1'b0;
    tick("snp2", 4'b0100, 1'b1, 1'b0); req[2] = 1'b0;
    tick("snp_idle", 4'b0000, 1'b1, 1'b0);

    set_req(0, CMD_READ, 32'h500);
    set_req(1, CMD_WRITE, 32'h110);
    for (int k = 0; k < 4; k++) tick($sformatf("stv%0d", k), 4'b0001, 1'b1, 1'b0);
    tick("stv_rr", 4'b0010, 1'b1, 1'b0); req[1] = 1'b0;
    tick("stv_r0a", 4'b0001, 1'b1, 1'b0);
    tick("stv_r0b", 4'b0001, 1'b1, 1'b0); req[0] = 1'b0;
    tick("stv_idle", 4'b0000, 1'b1, 1'b0);

    set_req(3, CMD_READ, 32'h330);
    cache_busy = 1'b1;
    for (int k = 0; k < 5; k++) tick($sformatf("busy%0d", k), 4'b0000, 1'b1, 1'b0);
    cache_busy = 1'b0;
    tick("busy_gnt", 4'b1000, 1'b1, 1'b0); req[3] = 1'b0;

    set_req(1, CMD_RESET, 32'h999);
    tick("qrst", 4'b0010, 1'b1, 1'b0); req[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick($sformatf("qrst_w%0d", k), 4'b0000, 1'b0, 1'b0);
    tick("qrst_run", 4'b0000, 1'b1, 1'b0);

    set_req(0, CMD_RESET, 32'h0);
    set_req(2, CMD_READ, 32'h2B0);
    tick("srst", 4'b0001, 1'b1, 1'b0); req[0] = 1'b0;
    for (int k = 0; k < 3; k++) tick($sformatf("srst_w%0d", k), 4'b0000, 1'b0, 1'b0);
    tick("srst_r2", 4'b0100, 1'b1, 1'b0); req[2] = 1'b0;
    tick("srst_idle", 4'b0000, 1'b1, 1'b0);

    // Hard reset together with a pending request: nothing may reach the cache.
    set_req(3, CMD_WRITE, 32'h3C0);
    reset = 1'b1;
    @(negedge clock);
    pop_check("mrst_in");
`ifdef CACHE_SCHED_STATS_EN
    check_stats("pre_mrst");
    for (int unsigned i = 0; i < NREQ; i++) gtally[i] = 0;
    stally = 0;
`endif
    push(CMD_NOP, 32'h0, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick("mrst0", 4'b0000, 1'b0, 1'b1);
    tick("mrst1", 4'b0000, 1'b0, 1'b0);
    tick("mrst2", 4'b0000, 1'b0, 1'b0);
    tick("mrst3", 4'b0000, 1'b0, 1'b0);
    tick("mrst_gnt", 4'b1000, 1'b1, 1'b0); req[3] = 1'b0;
    tick("mrst_fwd", 4'b0000, 1'b1, 1'b0);
`ifdef CACHE_SCHED_STATS_EN
    check_stats("final");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
